midi_note_receiver: RTL and testbench
=====================================

Name: midi_note_receiver

Overview:
Downstream counterpart of midi_note_sender. It deserialises a 31250-baud MIDI serial stream (8N1) and parses Note-On/Note-Off messages, including running status. Each complete message produces a one-cycle event pulse carrying channel, note and velocity. It sits between the MIDI-in pin (or a sender's tx, in loopback) and the synth/voice logic.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency
BAUD_RATE, 31250, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division, must be >= 4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial input, idles high
event_valid  output  1  one-cycle pulse, complete note message decoded
note_on  output  1  1 = note-on, 0 = note-off
channel  output  4  MIDI channel 0-15
note  output  7  note number
velocity  output  7  velocity
framing_err  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high while a byte is being received (START..STOP)

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0; UART to IDLE; running status cleared; synchroniser flops set to 1. Reset takes effect mid-byte or mid-message; any partial byte/message is discarded.
- rx passes through a 2-flop synchroniser before any use.
- UART FSM: IDLE -> START on synchronised falling edge. START: wait CLKS_PER_BIT/2; if rx still 0 go to DATA, else back to IDLE (glitch reject). DATA: sample every CLKS_PER_BIT, LSB first, 8 bits. STOP: sample after CLKS_PER_BIT; if 1, byte_valid; if 0, framing_err pulse, byte dropped, parser data count reset to 0 (running status kept). Then IDLE. A new start bit is accepted immediately after the stop sample.
- busy is high from START entry to the STOP sample cycle, inclusive.
- Parser, per received byte:
  - 0xF8-0xFF (realtime): ignored; parser state untouched.
  - 0x80-0x9F: running status = that byte; data count = 0.
  - 0xA0-0xEF: running status = "other"; subsequent data bytes are ignored.
  - 0xF0-0xF7: running status cleared; data bytes are ignored until the next channel status.
  - Data byte (bit7=0) with note status: count 0 stores note, count 1 stores velocity and emits the event, then count returns to 0 (running status retained).
  - Data byte with no/other status: ignored.
- Event: 0x9n with velocity 0 reports note_on=0. channel = status[3:0].
- event_valid asserts in the cycle after the stop-bit sample of the velocity byte. channel/note/velocity/note_on update in that same cycle and hold until the next event.
- Simultaneous reset with any event: reset wins.

Optional Feature:
MIDI_CHANNEL_FILTER_EN: adds input port filter_channel [3:0]. Events whose channel differs are suppressed (no event_valid, and outputs are not updated). Parsing is otherwise unchanged. Without the macro, the port is absent and all channels pass.

Decomposition:
- Package midi_pkg holds:
  - status-nibble constants: NOTE_OFF = 4'h8, NOTE_ON = 4'h9
  - realtime threshold 8'hF8
  - typedef for the UART state enum
  - typedef struct midi_event_t {note_on, channel, note, velocity}
- Natural sub-module midi_uart_rx (synchroniser + UART FSM, outputs byte_data/byte_valid/framing_err/busy). The parser stays in the top level.

Test Plan:
- CLKS_PER_BIT = 16 via CLK_FREQ_HZ=160, BAUD_RATE=10. Send 0x91 0x3C 0x64 -> one event_valid; note_on=1, channel=1, note=60, velocity=100; event_valid exactly one cycle.
- Running status: send 0x9F 0x46 0x32 0x46 0x00 -> two events: (1,15,70,50) then (0,15,70,0).
- Realtime interleave: send 0x80 0xF8 0x40 0xFE 0x7F -> single event (0,0,64,127).
- Framing error: send 0x90 0x40, then a byte with stop bit low, then 0x30 0x20 -> framing_err pulse; one event (1,0,48,32).
- Ignored statuses: send 0xB0 0x07 0x64, then 0xF0 0x01 0x02 -> no event_valid. Then 0x92 0x10 0x20 -> event (1,2,16,32).
- Reset mid-byte: drop reset during bit 4 of 0x3C after 0x90 -> outputs 0, busy 0. Then 0x90 0x3C 0x64 -> event (1,0,60,100). A data-only stream sent right after reset -> no event.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg
// Shared definitions for the MIDI note receiver:
//   - status-nibble constants for Note-Off / Note-On
//   - realtime-message threshold (bytes at or above it are ignored)
//   - UART receive state enum
//   - decoded note event record
//   - helper that classifies a byte as a note channel-status byte
package midi_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] RT_THRESHOLD = 8'hF8;
  localparam logic [7:0] SYS_FIRST    = 8'hF0;
  localparam logic [7:0] NO_STATUS    = 8'h00;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  typedef struct packed {
    logic       note_on;
    logic [3:0] channel;
    logic [6:0] note;
    logic [6:0] velocity;
  } midi_event_t;

  // True for 0x8n / 0x9n, the only statuses whose data bytes are decoded.
  function automatic logic is_note_status(input logic [7:0] b);
    return (b[7:4] == NOTE_OFF) || (b[7:4] == NOTE_ON);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx
// 8N1 serial receiver with a 2-flop input synchroniser.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   rx          asynchronous serial input, idles high
//   byte_data   last assembled byte (valid while byte_valid is high)
//   byte_valid  strobe in the stop-bit sample cycle when the stop bit is 1
//   framing_err strobe in the stop-bit sample cycle when the stop bit is 0
//   busy        high from START entry through the stop-sample cycle
// byte_valid / framing_err are combinational strobes so the parser can
// register its outputs in the very next cycle.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;

  // Synchroniser, edge-detect history and FSM state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= UART_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Next-state logic and stop-bit strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (state_q)
      UART_IDLE: begin
        // Falling edge of the synchronised line marks a start bit.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = UART_START;
          cnt_d   = '0;
        end else begin
          state_d = UART_IDLE;
        end
      end
      UART_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // Line back high at mid start bit: treat as a glitch.
          if (!rx_sync_q) begin
            state_d = UART_DATA;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          if (bit_idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UART_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = UART_IDLE;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
          end else begin
            framing_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = UART_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_data = shift_q;
  assign busy      = (state_q != UART_IDLE);

endmodule

// File: rtl/midi_note_receiver.sv
// midi_note_receiver
// Receives a MIDI serial stream and decodes Note-On / Note-Off messages,
// including running status. Each complete message yields a one-cycle
// event_valid pulse; channel/note/velocity/note_on hold until the next event.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   rx             MIDI serial input (asynchronous, idles high)
//   filter_channel only with MIDI_CHANNEL_FILTER_EN: channel to pass
//   event_valid    one-cycle pulse per decoded note message
//   note_on        1 = note-on, 0 = note-off (0x9n with velocity 0 is off)
//   channel        MIDI channel 0-15
//   note           note number
//   velocity       velocity
//   framing_err    one-cycle pulse, stop bit sampled low
//   busy           high while a byte is on the wire (START..STOP)
// Optional feature macro: MIDI_CHANNEL_FILTER_EN
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
`ifdef MIDI_CHANNEL_FILTER_EN
  input  logic [3:0] filter_channel,
`endif
  output logic       event_valid,
  output logic       note_on,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       framing_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  logic [7:0]  u_byte_s;
  logic        u_valid_s;
  logic        u_ferr_s;
  logic        u_busy_s;

  logic [7:0]  status_q, status_d;
  logic        data_cnt_q, data_cnt_d;
  logic [6:0]  note_buf_q, note_buf_d;
  logic        event_valid_q, event_valid_d;
  midi_event_t ev_q, ev_d;
  logic        framing_err_q, framing_err_d;

  midi_event_t new_ev_s;
  logic        fire_s;
  logic        pass_s;

  midi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (u_byte_s),
    .byte_valid (u_valid_s),
    .framing_err(u_ferr_s),
    .busy       (u_busy_s)
  );

  // Event assembled from the running status, stored note and incoming velocity.
  assign new_ev_s.note_on  = (status_q[7:4] == NOTE_ON) && (u_byte_s[6:0] != 7'd0);
  assign new_ev_s.channel  = status_q[3:0];
  assign new_ev_s.note     = note_buf_q;
  assign new_ev_s.velocity = u_byte_s[6:0];

`ifdef MIDI_CHANNEL_FILTER_EN
  assign pass_s = (new_ev_s.channel == filter_channel);
`else
  assign pass_s = 1'b1;
`endif

  // Parser registers and output event registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      status_q      <= NO_STATUS;
      data_cnt_q    <= 1'b0;
      note_buf_q    <= 7'd0;
      event_valid_q <= 1'b0;
      ev_q          <= '0;
      framing_err_q <= 1'b0;
    end else begin
      status_q      <= status_d;
      data_cnt_q    <= data_cnt_d;
      note_buf_q    <= note_buf_d;
      event_valid_q <= event_valid_d;
      ev_q          <= ev_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Byte-level parser: status tracking, data counting and event emission.
  always_comb begin
    status_d      = status_q;
    data_cnt_d    = data_cnt_q;
    note_buf_d    = note_buf_q;
    framing_err_d = u_ferr_s;
    fire_s        = 1'b0;
    if (u_ferr_s) begin
      // Dropped byte breaks the current data pair; running status survives.
      data_cnt_d = 1'b0;
    end else if (!u_valid_s) begin
      data_cnt_d = data_cnt_q;
    end else if (u_byte_s >= RT_THRESHOLD) begin
      // Realtime bytes may appear anywhere and never disturb parsing.
      data_cnt_d = data_cnt_q;
    end else if (u_byte_s[7]) begin
      data_cnt_d = 1'b0;
      if (u_byte_s < SYS_FIRST) begin
        // Channel status: note statuses are decoded, others only block data.
        status_d = u_byte_s;
      end else begin
        status_d = NO_STATUS;
      end
    end else if (is_note_status(status_q)) begin
      if (!data_cnt_q) begin
        note_buf_d = u_byte_s[6:0];
        data_cnt_d = 1'b1;
      end else begin
        data_cnt_d = 1'b0;
        fire_s     = 1'b1;
      end
    end else begin
      data_cnt_d = data_cnt_q;
    end

    event_valid_d = fire_s && pass_s;
    if (fire_s && pass_s) begin
      ev_d = new_ev_s;
    end else begin
      ev_d = ev_q;
    end
  end

  assign event_valid = event_valid_q;
  assign note_on     = ev_q.note_on;
  assign channel     = ev_q.channel;
  assign note        = ev_q.note;
  assign velocity    = ev_q.velocity;
  assign framing_err = framing_err_q;
  assign busy        = u_busy_s;

endmodule

// File: tb/tb_midi_note_receiver.sv
// Self-checking bench for midi_note_receiver (CLKS_PER_BIT = 16).
// Directed vector table, hand-written reset sequences and a randomized
// byte stream checked against a message-level reference model.
module tb_midi_note_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       event_valid, note_on, framing_err, busy;
  logic [3:0] channel;
  logic [6:0] note, velocity;

  midi_note_receiver #(
    .CLK_FREQ_HZ(160),
    .BAUD_RATE  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .event_valid(event_valid),
    .note_on    (note_on),
    .channel    (channel),
    .note       (note),
    .velocity   (velocity),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: collects events and framing pulses, flags multi-cycle pulses.
  logic [18:0] got_q[$];
  int          fe_cnt = 0;
  int          pw_viol = 0;
  logic        prev_ev = 1'b0;
  logic        prev_fe = 1'b0;

  always @(negedge clk) begin
    if (event_valid) begin
      got_q.push_back({note_on, channel, note, velocity});
      if (prev_ev) pw_viol <= pw_viol + 1;
    end
    if (framing_err) begin
      fe_cnt <= fe_cnt + 1;
      if (prev_fe) pw_viol <= pw_viol + 1;
    end
    prev_ev <= event_valid;
    prev_fe <= framing_err;
  end

  function automatic logic [18:0] ev(input int on, input int ch, input int nt, input int vel);
    logic [18:0] r;
    r = {on[0], ch[3:0], nt[6:0], vel[6:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: message-level view of MIDI running status.
  logic [18:0] exp_q[$];
  int mdl_rs = -1;
  int mdl_cnt = 0;
  int mdl_note = 0;

  task automatic model_reset();
    mdl_rs = -1;
    mdl_cnt = 0;
    mdl_note = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic ok);
    int v;
    v = int'(b);
    if (!ok) mdl_cnt = 0;
    else if (v >= 248) begin end
    else if (v >= 128) begin
      mdl_rs = (v <= 159) ? v : -1;
      mdl_cnt = 0;
    end else if (mdl_rs >= 0) begin
      if (mdl_cnt == 0) begin
        mdl_note = v;
        mdl_cnt = 1;
      end else begin
        exp_q.push_back(ev((mdl_rs >= 144 && v != 0) ? 1 : 0, mdl_rs % 16, mdl_note, v));
        mdl_cnt = 0;
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(CPB);
    end
    rx = stop_ok;
    ticks(CPB);
    rx = 1'b1;
    ticks(4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    ticks(3);
    reset = 1'b1;
    ticks(4);
    got_q.delete();
    fe_cnt = 0;
    pw_viol = 0;
    model_reset();
  endtask

  task automatic compare_events(input string tag, input int exp_n, input logic [18:0] e0,
                                input logic [18:0] e1);
    check({tag, "_count"}, got_q.size(), exp_n);
    if (exp_n > 0 && got_q.size() > 0) check({tag, "_ev0"}, got_q[0], e0);
    if (exp_n > 1 && got_q.size() > 1) check({tag, "_ev1"}, got_q[1], e1);
  endtask

  typedef struct {
    int          n;
    logic [71:0] bytes;  // first byte in the most significant used position
    int          bad;    // index of the byte sent with a low stop bit, -1 none
    int          exp_n;
    logic [18:0] e0;
    logic [18:0] e1;
    int          exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] b;
    logic       ok;
    int         cat;

    vecs[0] = '{3, 72'h91_3C_64, -1, 1, ev(1, 1, 60, 100), 19'd0, 0};
    vecs[1] = '{5, 72'h9F_46_32_46_00, -1, 2, ev(1, 15, 70, 50), ev(0, 15, 70, 0), 0};
    vecs[2] = '{5, 72'h80_F8_40_FE_7F, -1, 1, ev(0, 0, 64, 127), 19'd0, 0};
    vecs[3] = '{5, 72'h90_40_55_30_20, 2, 1, ev(1, 0, 48, 32), 19'd0, 1};
    vecs[4] = '{9, 72'hB0_07_64_F0_01_02_92_10_20, -1, 1, ev(1, 2, 16, 32), 19'd0, 0};

    // Reset state.
    ticks(4);
    check("reset_outputs",
          {25'd0, event_valid, note_on, channel, note, velocity, framing_err, busy}, 32'd0);
    do_reset();

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) begin
        b = vecs[v].bytes[8*(vecs[v].n-1-i) +: 8];
        send_byte(b, (i != vecs[v].bad));
      end
      ticks(40);
      compare_events($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].e0, vecs[v].e1);
      check($sformatf("vec%0d_framing", v), fe_cnt, vecs[v].exp_fe);
      check($sformatf("vec%0d_pulse_width", v), pw_viol, 0);
      check($sformatf("vec%0d_busy_idle", v), busy, 1'b0);
    end

    // Reset in the middle of a byte (bit 4 of 0x3C following 0x90).
    do_reset();
    send_byte(8'h91, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(8'h90, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    ticks(CPB);
    b = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      ticks(CPB);
    end
    rx = b[4];
    ticks(8);
    check("busy_mid_byte", busy, 1'b1);
    check("pre_reset_event", got_q.size(), 1);
    reset = 1'b0;
    ticks(1);
    check("midbyte_reset_outputs",
          {25'd0, event_valid, note_on, channel, note, velocity, framing_err, busy}, 32'd0);
    rx = 1'b1;
    ticks(2);
    reset = 1'b1;
    ticks(40);
    got_q.delete();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    ticks(40);
    compare_events("after_reset", 1, ev(1, 0, 60, 100), 19'd0);

    // Running status is cleared by reset: data-only stream yields nothing.
    do_reset();
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    ticks(40);
    check("data_only_after_reset", got_q.size(), 0);

    // Randomized stream against the reference model.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cat = $urandom_range(0, 9);
      if (cat <= 2) b = 8'h80 | 8'($urandom_range(0, 31));
      else if (cat <= 7) b = 8'($urandom_range(0, 127));
      else if (cat == 8) b = 8'($urandom_range(248, 255));
      else b = 8'($urandom_range(160, 247));
      ok = ($urandom_range(0, 19) != 0);
      model_byte(b, ok);
      send_byte(b, ok);
    end
    ticks(40);
    check("random_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("random_ev%0d", i), got_q[i], exp_q[i]);
    end
    check("random_pulse_width", pw_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
